// File: rtl/fifo_tx_drain.sv
// Drain stage between the FIFO read side and the UART transmitter.
// Pops one byte per frame from a first-word-fall-through FIFO, offers it to
// the transmitter with a valid/busy handshake, optionally holds an idle gap
// after each frame, flags a transmitter that never accepts, and counts
// accepted frames.
module fifo_tx_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TXDATA_VALID,
    output logic                  DRAIN_BUSY,
    output logic                  TIMEOUT_ERR,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT
);

    // Counter widths are clamped to one bit so degenerate parameters still elaborate.
    localparam int TO_W  = (TIMEOUT > 32'sd1) ? $clog2(TIMEOUT) : 32'sd1;
    localparam int GAP_W = (GAP_CYCLES > 32'sd1) ? $clog2(GAP_CYCLES) : 32'sd1;
    localparam bit HAS_GAP = (GAP_CYCLES > 32'sd0);

    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 32'sd1);
    localparam logic [TO_W-1:0]      TO_ONE   = TO_W'(1'b1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(HAS_GAP ? (GAP_CYCLES - 32'sd1) : 32'sd0);
    localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [TO_W-1:0]         to_cnt_r, to_cnt_s;
    logic [GAP_W-1:0]        gap_cnt_r, gap_cnt_s;
    logic [DATA_WIDTH-1:0]   data_r, data_s;
    logic                    r_inc_r, r_inc_s;
    logic                    valid_r, valid_s;
    logic                    busy_r, busy_s;
    logic                    err_r, err_s;
    logic [CNT_WIDTH-1:0]    cnt_r, cnt_s;

    // Next-state and next-output logic; pulses default low, data and counters hold.
    always_comb begin
        state_s   = state_r;
        to_cnt_s  = to_cnt_r;
        gap_cnt_s = gap_cnt_r;
        data_s    = data_r;
        cnt_s     = cnt_r;
        r_inc_s   = 1'b0;
        valid_s   = 1'b0;
        err_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Launch only when the transmitter is free, so a byte is never offered to a busy TX.
                if (EN && !EMPTY && !TX_BUSY) begin
                    data_s   = RD_DATA;
                    r_inc_s  = 1'b1;
                    valid_s  = 1'b1;
                    to_cnt_s = '0;
                    state_s  = ST_LAUNCH;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                // Acceptance wins over the timeout when both land on the same cycle.
                if (TX_BUSY) begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = ST_WAIT_LO;
                end else if (to_cnt_r == TO_LAST) begin
                    // Byte is dropped: it was already popped and is not re-queued.
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    valid_s  = 1'b1;
                    to_cnt_s = to_cnt_r + TO_ONE;
                end
            end
            ST_WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (HAS_GAP) begin
                        gap_cnt_s = '0;
                        state_s   = ST_GAP;
                    end else begin
                        state_s   = ST_IDLE;
                    end
                end else begin
                    state_s = ST_WAIT_LO;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Busy flag is derived from the next state so it is registered alongside it.
        busy_s = (state_s != ST_IDLE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            to_cnt_r  <= '0;
            gap_cnt_r <= '0;
            data_r    <= '0;
            r_inc_r   <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            cnt_r     <= '0;
        end else begin
            state_r   <= state_s;
            to_cnt_r  <= to_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            data_r    <= data_s;
            r_inc_r   <= r_inc_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            err_r     <= err_s;
            cnt_r     <= cnt_s;
        end
    end

    assign R_INC        = r_inc_r;
    assign TX_P_DATA    = data_r;
    assign TXDATA_VALID = valid_r;
    assign DRAIN_BUSY   = busy_r;
    assign TIMEOUT_ERR  = err_r;
    assign FRAME_CNT    = cnt_r;

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Randomized scoreboard bench for fifo_tx_drain: a FIFO model and a UART TX
// model drive the DUT; every pushed byte carries its own TX behaviour, and a
// monitor checks order, handshake length, timeouts, frame count and spacing.
module tb_fifo_tx_drain;

    localparam int DW  = 8;
    localparam int GAP = 4;
    localparam int TO  = 16;
    localparam int CW  = 4;
    localparam int CNT_MOD = 1 << CW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          EN = 1'b0;
    logic          EMPTY = 1'b1;
    logic          TX_BUSY = 1'b0;
    logic [DW-1:0] RD_DATA = '0;
    logic          R_INC, TXDATA_VALID, DRAIN_BUSY, TIMEOUT_ERR;
    logic [DW-1:0] TX_P_DATA;
    logic [CW-1:0] FRAME_CNT;

    fifo_tx_drain #(
        .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .EMPTY(EMPTY), .RD_DATA(RD_DATA),
        .R_INC(R_INC), .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA),
        .TXDATA_VALID(TXDATA_VALID), .DRAIN_BUSY(DRAIN_BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    // One expected frame: the byte plus how the TX model will treat it.
    typedef struct {
        logic [7:0] data;
        int         delay;
        int         len;
        bit         accept;
    } frame_t;

    frame_t     sb_q[$];
    logic [7:0] fifo_q[$];

    int total = 0;
    int bad   = 0;

    bit rst_req   = 1'b1;
    int ext_busy  = 0;
    int tx_delay  = 1;
    int tx_len    = 1;
    bit tx_accept = 1'b1;

    int cyc = 0;
    int n_launch = 0;
    int n_rinc = 0;
    int cnt_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] d, input int dl, input int ln, input bit acc);
        frame_t f;
        f.data = d; f.delay = dl; f.len = ln; f.accept = acc;
        sb_q.push_back(f);
        fifo_q.push_back(d);
    endtask

    task automatic step();
        @(negedge CLK);
        #2;
    endtask

    task automatic wait_idle(input int limit);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < limit) begin
            step();
            n++;
            if (DRAIN_BUSY === 1'b0 && TX_BUSY === 1'b0 && (fifo_q.size() == 0 || !EN))
                quiet++;
            else
                quiet = 0;
        end
        chk("drain_idle", (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_launch(input int base);
        int n;
        n = 0;
        while (n_launch == base && n < 100) begin
            step();
            n++;
        end
        chk("launch_seen", (n_launch != base) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Environment: FIFO pops on R_INC, TX raises busy after the frame's delay.
    initial begin : env
        logic valid_q;
        logic rinc_q;
        int   vcnt;
        int   busy_left;
        vcnt = 0;
        busy_left = 0;
        forever begin
            @(negedge CLK);
            valid_q = TXDATA_VALID;
            rinc_q  = R_INC;
            @(posedge CLK);
            #1;
            RST = rst_req;
            if (rinc_q === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
            EMPTY   = (fifo_q.size() == 0);
            RD_DATA = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
            if (rst_req) begin
                vcnt = 0;
                busy_left = 0;
            end else if (busy_left > 0) begin
                busy_left--;
            end else if (valid_q === 1'b1 && tx_accept) begin
                vcnt++;
                if (vcnt >= tx_delay) begin
                    busy_left = tx_len;
                    vcnt = 0;
                end
            end else begin
                vcnt = 0;
            end
            if (ext_busy > 0) ext_busy--;
            TX_BUSY = (busy_left > 0) || (ext_busy > 0);
        end
    end

    // Monitor: pops the scoreboard at each launch and checks the frame outcome.
    initial begin : mon
        logic   prev_valid, prev_busy, rst_chk, frame_active, launch, fall;
        int     launch_cyc, exp_launch_at, exp_dur;
        frame_t cur;
        prev_valid = 1'b0; prev_busy = 1'b0; rst_chk = 1'b0; frame_active = 1'b0;
        launch_cyc = 0; exp_launch_at = 0;
        cur.data = 8'h00; cur.delay = 1; cur.len = 1; cur.accept = 1'b1;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST !== 1'b0) begin
                prev_valid = 1'b0;
                prev_busy = (TX_BUSY === 1'b1);
                rst_chk = 1'b1;
                frame_active = 1'b0;
                exp_launch_at = 0;
                cnt_exp = 0;
            end else begin
                if (rst_chk) begin
                    chk("rst_r_inc", R_INC, 32'd0);
                    chk("rst_valid", TXDATA_VALID, 32'd0);
                    chk("rst_data", TX_P_DATA, 32'd0);
                    chk("rst_drain_busy", DRAIN_BUSY, 32'd0);
                    chk("rst_timeout_err", TIMEOUT_ERR, 32'd0);
                    chk("rst_frame_cnt", FRAME_CNT, 32'd0);
                    rst_chk = 1'b0;
                end
                launch = !prev_valid && (TXDATA_VALID === 1'b1);
                fall   = prev_valid && (TXDATA_VALID !== 1'b1);
                chk("r_inc_pulse", R_INC, launch);
                if (exp_launch_at != 0 && (launch || cyc >= exp_launch_at)) begin
                    chk("launch_spacing", launch ? cyc : 0, exp_launch_at);
                    exp_launch_at = 0;
                end
                if (launch) begin
                    n_launch++;
                    chk("launch_while_tx_busy", prev_busy, 32'd0);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_launch", 32'd1, 32'd0);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("tx_data", TX_P_DATA, cur.data);
                    end
                    tx_delay = cur.delay;
                    tx_len = cur.len;
                    tx_accept = cur.accept;
                    launch_cyc = cyc;
                    frame_active = 1'b1;
                end
                if (TXDATA_VALID === 1'b1) begin
                    chk("data_stable", TX_P_DATA, cur.data);
                    chk("drain_busy_valid", DRAIN_BUSY, 32'd1);
                end
                if (fall) begin
                    exp_dur = cur.accept ? cur.delay + 1 : TO;
                    chk("valid_len", cyc - launch_cyc, exp_dur);
                    if (cur.accept) cnt_exp = (cnt_exp + 1) % CNT_MOD;
                    else frame_active = 1'b0;
                    chk("frame_cnt", FRAME_CNT, cnt_exp);
                end
                chk("timeout_err", TIMEOUT_ERR, fall && !cur.accept);
                if (prev_busy && TX_BUSY === 1'b0 && frame_active) begin
                    frame_active = 1'b0;
                    if (EN && fifo_q.size() > 0) exp_launch_at = cyc + 2 + GAP;
                end
                if (R_INC === 1'b1) n_rinc++;
                prev_valid = (TXDATA_VALID === 1'b1);
                prev_busy = (TX_BUSY === 1'b1);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized frame streams.
    initial begin : stim
        int base;
        int acc;
        bit a;
        repeat (3) step();
        rst_req = 1'b0;
        step();

        // Single byte, TX accepts one cycle after seeing valid.
        push(8'hA5, 1, 3, 1'b1);
        EN = 1'b1;
        wait_idle(200);
        chk("t1_frame_cnt", FRAME_CNT, 32'd1);
        chk("t1_pops", n_rinc, 32'd1);

        // Three bytes, long busy, gap enforced between them.
        push(8'h11, 1, 10, 1'b1);
        push(8'h22, 1, 10, 1'b1);
        push(8'h33, 1, 10, 1'b1);
        wait_idle(300);
        chk("t2_frame_cnt", FRAME_CNT, 32'd4);
        chk("t2_sb_left", sb_q.size(), 32'd0);
        chk("t2_fifo_left", fifo_q.size(), 32'd0);

        // TX never accepts: byte dropped after the timeout.
        push(8'h5A, 1, 1, 1'b0);
        wait_idle(200);
        chk("t3_frame_cnt", FRAME_CNT, 32'd4);
        chk("t3_pops", n_rinc, 32'd5);

        // TX accepts on the last permitted cycle.
        push(8'hC3, TO - 1, 2, 1'b1);
        wait_idle(200);
        chk("t3b_frame_cnt", FRAME_CNT, 32'd5);

        // EN dropped while waiting for busy to fall.
        base = n_launch;
        push(8'h01, 1, 8, 1'b1);
        push(8'h02, 1, 8, 1'b1);
        push(8'h03, 1, 8, 1'b1);
        wait_launch(base);
        repeat (3) step();
        EN = 1'b0;
        wait_idle(200);
        chk("t4_pops", n_rinc, 32'd7);
        chk("t4_fifo_left", fifo_q.size(), 32'd2);
        chk("t4_drain_busy", DRAIN_BUSY, 32'd0);
        repeat (20) step();
        chk("t4_no_more_pops", n_rinc, 32'd7);
        EN = 1'b1;
        wait_idle(300);
        chk("t4_frame_cnt", FRAME_CNT, 32'd8);
        chk("t4_sb_left", sb_q.size(), 32'd0);

        // TX already busy with external traffic when data arrives.
        ext_busy = 8;
        push(8'h7E, 2, 1, 1'b1);
        wait_idle(200);
        chk("t5_frame_cnt", FRAME_CNT, 32'd9);

        // Reset in the first launch cycle; next byte goes out normally.
        base = n_launch;
        push(8'h3C, 6, 2, 1'b1);
        push(8'h4D, 2, 3, 1'b1);
        wait_launch(base);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        wait_idle(300);
        chk("t6_frame_cnt", FRAME_CNT, 32'd1);
        chk("t6_sb_left", sb_q.size(), 32'd0);
        chk("t6_fifo_left", fifo_q.size(), 32'd0);

        // Clean reset, then 17 accepted random frames wrap the 4-bit counter.
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        step();
        for (int i = 0; i < 17; i++)
            push(8'($urandom), $urandom_range(1, TO - 1), $urandom_range(1, 6), 1'b1);
        wait_idle(3000);
        chk("t7_wrap", FRAME_CNT, 32'd1);
        chk("t7_sb_left", sb_q.size(), 32'd0);

        // Mixed random stream with occasional timeouts.
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 3) != 0);
            if (a) acc++;
            push(8'($urandom), $urandom_range(1, TO - 1), $urandom_range(1, 6), a);
        end
        wait_idle(3000);
        chk("t8_frame_cnt", FRAME_CNT, (1 + acc) % CNT_MOD);
        chk("t8_sb_left", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit in case the run stalls somewhere unbounded.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
